// File: rtl/icache_fill_pkg.sv
// Shared sizes, address split and FSM encoding for the instruction-cache refill slice.
package icache_fill_pkg;

    localparam int unsigned WORD_SIZE  = 32;
    localparam int unsigned BLOCK_SIZE = 1024;
    localparam int unsigned LINES      = 8;
    localparam int unsigned BEATS      = BLOCK_SIZE / WORD_SIZE;

    localparam int unsigned OFF_W  = $clog2(BLOCK_SIZE / 8);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = WORD_SIZE - OFF_W - IDX_W;
    localparam int unsigned BEAT_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FILL  = 2'd2,
        WRITE = 2'd3
    } state_t;

    function automatic logic [WORD_SIZE-1:0] block_base(input logic [WORD_SIZE-1:0] a);
        return a & ~(WORD_SIZE'(BLOCK_SIZE / 8 - 1));
    endfunction

endpackage

// File: rtl/icache_fill_if.sv
// Fetch-side lookup and instruction-memory burst signals of the refill cache.
interface icache_fill_if;
    import icache_fill_pkg::*;

    logic [WORD_SIZE-1:0]  in;
    logic [BLOCK_SIZE-1:0] out;
    logic                  hit;
    logic                  mem_req;
    logic [WORD_SIZE-1:0]  mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [WORD_SIZE-1:0]  mem_rdata;

    modport slave (
        input  in, mem_gnt, mem_rvalid, mem_rdata,
        output out, hit, mem_req, mem_addr
    );

    modport master (
        output in, mem_gnt, mem_rvalid, mem_rdata,
        input  out, hit, mem_req, mem_addr
    );

endinterface

// File: rtl/icache_fill_line_buf.sv
// Refill assembly buffer: packs burst beats into one block, first beat in the top word.
module icache_line_buf
    import icache_fill_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WORD_SIZE-1:0]  rdata,
    output logic [BLOCK_SIZE-1:0] data,
    output logic                  done
);

    logic [BEATS-1:0][WORD_SIZE-1:0] words;
    logic [BEAT_W-1:0]               beat;

    // Beat k lands in word BEATS-1-k, so offset 0 sits in the block's MSBs.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            beat <= '0;
        end else if (load) begin
            words[BEAT_W'(BEATS - 1) - beat] <= rdata;
            beat                             <= beat + 1'b1;
        end
    end

    assign data = words;
    assign done = load && (beat == BEAT_W'(BEATS - 1));

endmodule

// File: rtl/icache_fill.sv
// Direct-mapped instruction cache with blocking burst refill.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache_fill
    import icache_fill_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
`ifdef ICACHE_STATS_EN
    output logic [WORD_SIZE-1:0] stat_hits,
    output logic [WORD_SIZE-1:0] stat_misses,
`endif
    icache_fill_if.slave         bus
);

    state_t                state;
    logic [WORD_SIZE-1:0]  miss_addr;
    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tags  [LINES];
    logic [BLOCK_SIZE-1:0] lines [LINES];

    logic                  hit_q;
    logic                  req_q;
    logic [BLOCK_SIZE-1:0] out_q;

    logic [IDX_W-1:0]      in_idx;
    logic [IDX_W-1:0]      miss_idx;
    logic [TAG_W-1:0]      in_tag;
    logic [TAG_W-1:0]      miss_tag;
    logic                  lookup_hit;
    logic                  buf_clear;
    logic                  buf_load;
    logic                  buf_done;
    logic [BLOCK_SIZE-1:0] buf_data;

    assign in_idx     = bus.in[OFF_W +: IDX_W];
    assign in_tag     = bus.in[WORD_SIZE-1 -: TAG_W];
    assign miss_idx   = miss_addr[OFF_W +: IDX_W];
    assign miss_tag   = miss_addr[WORD_SIZE-1 -: TAG_W];
    assign lookup_hit = valid[in_idx] && (tags[in_idx] == in_tag);

    // Beats are only accepted while filling; strays in other states are dropped.
    assign buf_clear  = (state == REQ) && bus.mem_gnt;
    assign buf_load   = (state == FILL) && bus.mem_rvalid;

    icache_line_buf u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .clear (buf_clear),
        .load  (buf_load),
        .rdata (bus.mem_rdata),
        .data  (buf_data),
        .done  (buf_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hit_q     <= 1'b0;
            req_q     <= 1'b0;
            out_q     <= '0;
            miss_addr <= '0;
            valid     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lookup_hit) begin
                        hit_q <= 1'b1;
                        out_q <= lines[in_idx];
                    end else begin
                        hit_q     <= 1'b0;
                        req_q     <= 1'b1;
                        miss_addr <= block_base(bus.in);
                        state     <= REQ;
                    end
                end
                REQ: begin
                    hit_q <= 1'b0;
                    if (bus.mem_gnt) begin
                        req_q <= 1'b0;
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (buf_done) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    valid[miss_idx] <= 1'b1;
                    state           <= IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays need no reset: valid bits gate every read.
    always_ff @(posedge clk) begin
        if (!rst && state == WRITE) begin
            lines[miss_idx] <= buf_data;
            tags[miss_idx]  <= miss_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state == IDLE) begin
            if (lookup_hit) begin
                if (stat_hits != '1) begin
                    stat_hits <= stat_hits + 1'b1;
                end
            end else if (stat_misses != '1) begin
                stat_misses <= stat_misses + 1'b1;
            end
        end
    end
`endif

    assign bus.hit      = hit_q;
    assign bus.out      = out_q;
    assign bus.mem_req  = req_q;
    assign bus.mem_addr = miss_addr;

endmodule

// File: tb/tb_icache_fill.sv
// Self-checking bench for icache_fill: directed plan steps plus randomized lookups,
// checked against an address-level cache model and a behavioural burst memory.
module tb_icache_fill;
    import icache_fill_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    icache_fill_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    icache_fill dut (
        .clk         (clk),
        .rst         (rst),
`ifdef ICACHE_STATS_EN
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    int unsigned stall_total = 0;
    int unsigned beats_sent = 0;
    int unsigned gnt_delay = 0;
    int unsigned gap_mode = 0;
    bit          junk_en = 1'b0;

    bit          mvalid [8];
    logic [21:0] mtag   [8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    function automatic logic [1023:0] block_of(input logic [31:0] a);
        logic [1023:0] blk;
        logic [31:0]   base;
        base = a & 32'hFFFF_FF80;
        for (int k = 0; k < 32; k++) blk[1023 - 32*k -: 32] = mem_word(base + 32'(4*k));
        return blk;
    endfunction

    function automatic bit mhit(input logic [31:0] a);
        return mvalid[a[9:7]] && (mtag[a[9:7]] == a[31:10]);
    endfunction

    task automatic install(input logic [31:0] a);
        mvalid[a[9:7]] = 1'b1;
        mtag[a[9:7]]   = a[31:10];
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        int w;
        nvec++;
        assert (got === exp) else begin
            nerr++;
            w = 0;
            for (int i = 31; i >= 0; i--) begin
                if (got[1023 - 32*i -: 32] !== exp[1023 - 32*i -: 32]) w = i;
            end
            $error("FAIL %s word%0d got=%h exp=%h", tag, w,
                   got[1023 - 32*w -: 32], exp[1023 - 32*w -: 32]);
        end
    endtask

    // Burst memory: grants after gnt_delay cycles, then one beat per cycle with optional gaps.
    initial begin : memory
        logic [31:0] base;
        bit          ab;
        int unsigned gap;
        forever begin
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = junk_en && ($urandom_range(0, 2) == 0);
            bus.mem_rdata  = $urandom;
            @(negedge clk); #1;
            if (!rst && bus.mem_req) begin
                base       = bus.mem_addr;
                beats_sent = 0;
                ab         = 1'b0;
                for (int unsigned i = 0; i < gnt_delay && !ab; i++) begin
                    bus.mem_rvalid = junk_en && ($urandom_range(0, 1) == 0);
                    bus.mem_rdata  = $urandom;
                    stall_total++;
                    @(negedge clk); #1;
                    ab = rst;
                end
                if (!ab) begin
                    bus.mem_gnt = 1'b1;
                    @(negedge clk); #1;
                    ab          = rst;
                    bus.mem_gnt = 1'b0;
                end
                for (int k = 0; k < 32 && !ab; k++) begin
                    gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 2);
                    for (int unsigned g = 0; g < gap && !ab; g++) begin
                        bus.mem_rvalid = 1'b0;
                        bus.mem_rdata  = $urandom;
                        stall_total++;
                        @(negedge clk); #1;
                        ab = rst;
                    end
                    if (!ab) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = mem_word(base + 32'(4*k));
                        beats_sent     = k + 1;
                        @(negedge clk); #1;
                        ab = rst;
                    end
                end
                if (!ab) begin
                    bus.mem_rvalid = 1'b0;
                    @(negedge clk); #1;
                end
            end
        end
    end

    // Presents a at the current negedge; with k>0 and a missing, switches in to b after k edges.
    task automatic lookup(input logic [31:0] a, input logic [31:0] b, input int k);
        int          n;
        int unsigned nmiss;
        int unsigned s0;
        logic [31:0] f;
        bit          sw;
        bit          prev_req;
        logic [31:0] q[$];
        bus.in = a;
        s0     = stall_total;
        nmiss  = 0;
        f      = a;
        sw     = 1'b0;
        if (!mhit(a)) begin
            nmiss++;
            q.push_back(a & 32'hFFFF_FF80);
            install(a);
            if (k > 0) begin
                sw = 1'b1;
                f  = b;
                if (!mhit(b)) begin
                    nmiss++;
                    q.push_back(b & 32'hFFFF_FF80);
                    install(b);
                end
            end
        end
        prev_req = 1'b0;
        n        = 0;
        while (n < 800) begin
            @(posedge clk); #1;
            n++;
            if (bus.mem_req && !prev_req) begin
                if (q.size() == 0) chk("req_extra", bus.mem_req, 0);
                else               chk("req_addr", bus.mem_addr, q.pop_front());
            end
            prev_req = bus.mem_req;
            if (bus.hit) break;
            if (sw && n == k) begin
                @(negedge clk);
                bus.in = b;
            end
        end
        chk("hit", bus.hit, 1);
        chk("latency", 64'(n), 64'(1 + 35*nmiss + (stall_total - s0)));
        chk_blk("out", bus.out, block_of(f));
        chk("req_count", 64'(q.size()), 0);
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] b, input int k);
        @(negedge clk);
        lookup(a, b, k);
    endtask

    task automatic rst_mid(input logic [31:0] a, input int unsigned at_beat);
        int n;
        @(negedge clk);
        beats_sent = 0;
        bus.in     = a;
        n          = 0;
        while (n < 300 && beats_sent < at_beat) begin
            @(negedge clk); #2;
            n++;
        end
        chk("rstmid_reach", 64'(beats_sent), 64'(at_beat));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_hit", bus.hit, 0);
        chk("rstmid_req", bus.mem_req, 0);
        for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        lookup(a, 32'h0, 0);
    endtask

    initial begin : main
        logic [21:0] tp[3];
        logic [31:0] a;
        logic [31:0] b;
        int          k;
        bus.in = '0;
        for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_hit", bus.hit, 0);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk_blk("rst_out", bus.out, '0);

        // Cold miss, zero-wait memory.
        rst = 1'b0;
        lookup(32'h0000_0000, 32'h0, 0);
        chk("cold_w0", bus.out[1023:992], 32'hA000_0000);
        chk("cold_w31", bus.out[31:0], 32'hA000_001F);

        step(32'h0000_0044, 32'h0, 0);
        step(32'h0000_0400, 32'h0, 0);
        step(32'h0000_0000, 32'h0, 0);

        gnt_delay = 5;
        gap_mode  = 1;
        step(32'h0000_1080, 32'h0, 0);

        gnt_delay = 0;
        gap_mode  = 0;
        step(32'h0000_0080, 32'h0000_0100, 8);
        step(32'h0000_00C0, 32'h0, 0);
        step(32'h0000_0104, 32'h0, 0);

        step(32'h0000_0400, 32'h0, 0);
        rst_mid(32'h0000_0000, 10);

        junk_en = 1'b1;
        for (int i = 0; i < 3; i++) tp[i] = 22'($urandom);
        for (int it = 0; it < 80; it++) begin
            gnt_delay = $urandom_range(0, 3);
            gap_mode  = $urandom_range(0, 2);
            a[31:10]  = tp[$urandom_range(0, 2)];
            a[9:7]    = 3'($urandom_range(0, 7));
            a[6:0]    = 7'($urandom);
            b[31:10]  = tp[$urandom_range(0, 2)];
            b[9:7]    = 3'($urandom_range(0, 7));
            b[6:0]    = 7'($urandom);
            k         = (!mhit(a) && $urandom_range(0, 3) == 0) ? $urandom_range(1, 25) : 0;
            step(a, b, k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
